// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
// Stage-control bundle plus the RUN/MDU state encoding.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [0:0] {S_RUN, S_MDU} hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic de_en;
    logic em_en;
    logic mw_en;
    logic fd_fl;
    logic de_fl;
    logic em_fl;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTL_RUN  = 8'b11111_000;
  localparam stage_ctrl_t CTL_ZERO = 8'b00000_000;
  localparam stage_ctrl_t CTL_MDU  = 8'b00011_001;
  localparam stage_ctrl_t CTL_BR   = 8'b11111_110;
  localparam stage_ctrl_t CTL_LUH  = 8'b00111_010;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from D/E/M and the stage enable/flush bundle.
// master drives the hazard sources, slave is the sequencer.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] d_rs1;
  logic [REG_W-1:0] d_rs2;
  logic [REG_W-1:0] e_rd;
  logic d_use_rs1;
  logic d_use_rs2;
  logic e_is_load;
  logic e_branch_taken;
  logic e_mdu_start;
  logic m_mem_wait;

  logic pc_enable;
  logic fd_enable;
  logic de_enable;
  logic em_enable;
  logic mw_enable;
  logic fd_flush;
  logic de_flush;
  logic em_flush;
  logic mdu_busy;

  modport master (
    output d_rs1, d_rs2, e_rd,
    output d_use_rs1, d_use_rs2,
    output e_is_load, e_branch_taken,
    output e_mdu_start, m_mem_wait,
    input  pc_enable, fd_enable, de_enable,
    input  em_enable, mw_enable,
    input  fd_flush, de_flush, em_flush,
    input  mdu_busy
  );

  modport slave (
    input  d_rs1, d_rs2, e_rd,
    input  d_use_rs1, d_use_rs2,
    input  e_is_load, e_branch_taken,
    input  e_mdu_start, m_mem_wait,
    output pc_enable, fd_enable, de_enable,
    output em_enable, mw_enable,
    output fd_flush, de_flush, em_flush,
    output mdu_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline.
// Priority: mem wait, MDU occupancy, branch redirect, load-use.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = 4;
  localparam int INIT_I = (MDU_LAT > 3) ? MDU_LAT - 3 : 0;
  localparam logic [CW-1:0] CNT_INIT = CW'(INIT_I);
  localparam logic MDU_MULTI = (MDU_LAT > 1);
  localparam logic MDU_LONG  = (MDU_LAT > 2);

  hz_state_t   state;
  hz_state_t   state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  stage_ctrl_t ctl;
  logic        luh;
  logic        br_inc;
  logic        rs1_hit;
  logic        rs2_hit;

  assign rs1_hit = hz.d_use_rs1 && (hz.d_rs1 == hz.e_rd);
  assign rs2_hit = hz.d_use_rs2 && (hz.d_rs2 == hz.e_rd);
  assign luh = hz.e_is_load && (hz.e_rd != '0)
             && (rs1_hit || rs2_hit);

  always_comb begin
    ctl     = CTL_RUN;
    state_n = state;
    cnt_n   = cnt;
    br_inc  = 1'b0;
    if (!rst) begin
      ctl = CTL_ZERO;
    end else begin
      unique case (state)
        S_RUN: begin
          if (hz.m_mem_wait) begin
            ctl = CTL_ZERO;
          end else if (hz.e_mdu_start && MDU_MULTI) begin
            ctl = CTL_MDU;
            if (MDU_LONG) begin
              state_n = S_MDU;
              cnt_n   = CNT_INIT;
            end
          end else if (hz.e_branch_taken) begin
            ctl    = CTL_BR;
            br_inc = 1'b1;
          end else if (luh) begin
            ctl = CTL_LUH;
          end
        end
        S_MDU: begin
          // cnt==0 is the last stalled cycle; release follows in S_RUN
          if (hz.m_mem_wait) begin
            ctl = CTL_ZERO;
          end else begin
            ctl = CTL_MDU;
            if (cnt != '0) cnt_n = cnt - CW'(1);
            else state_n = S_RUN;
          end
        end
        default: begin
          state_n = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign hz.pc_enable = ctl.pc_en;
  assign hz.fd_enable = ctl.fd_en;
  assign hz.de_enable = ctl.de_en;
  assign hz.em_enable = ctl.em_en;
  assign hz.mw_enable = ctl.mw_en;
  assign hz.fd_flush  = ctl.fd_fl;
  assign hz.de_flush  = ctl.de_fl;
  assign hz.em_flush  = ctl.em_fl;
  assign hz.mdu_busy  = (state == S_MDU);

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctl.pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_inc),
    .count (flush_cnt)
  );

  a_br_mdu: assert property (@(posedge clk) disable iff (!rst)
    !(hz.e_branch_taken && hz.e_mdu_start));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two DUTs (MDU_LAT 4/CNT_W 16, MDU_LAT 2/CNT_W 4)
// checked against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       ld;
    logic       bt;
    logic       ms;
    logic       mw;
  } in_t;

  typedef struct packed {
    logic [7:0]  ctl;
    logic        busy;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  logic [15:0] a_stall, a_flush;
  logic [3:0]  b_stall, b_flush;

  pipe_hazard_ctrl_if hz_a ();
  pipe_hazard_ctrl_if hz_b ();

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .hz(hz_a.slave),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_ctrl #(.MDU_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .hz(hz_b.slave),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  int total = 0;
  int bad = 0;
  exp_t [1:0] q[$];

  int left [2];
  int sc [2];
  int fc [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  // Remaining E-occupancy cycles of an MDU op, counted down per
  // non-frozen cycle; the release cycle is the one after it hits 0.
  task automatic model(input int k, input in_t i, output exp_t e);
    logic pc, fd, de, em, mw, ff, dfl, ef, fi, luh;
    pc = 1; fd = 1; de = 1; em = 1; mw = 1;
    ff = 0; dfl = 0; ef = 0; fi = 0;
    luh = i.ld && (i.rd != 0) &&
          ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    e.busy = (left[k] > 0);
    e.sc = 16'(sc[k]);
    e.fc = 16'(fc[k]);
    if (!i.rst) begin
      {pc, fd, de, em, mw} = 5'b0;
    end else if (i.mw) begin
      {pc, fd, de, em, mw} = 5'b0;
    end else if (left[k] > 0) begin
      {pc, fd, de} = 3'b0; ef = 1;
      left[k] = left[k] - 1;
    end else if (i.ms && lat_of(k) > 1) begin
      {pc, fd, de} = 3'b0; ef = 1;
      left[k] = lat_of(k) - 2;
    end else if (i.bt) begin
      ff = 1; dfl = 1; fi = 1;
    end else if (luh) begin
      pc = 0; fd = 0; dfl = 1;
    end
    e.ctl = {pc, fd, de, em, mw, ff, dfl, ef};
    if (!i.rst) begin
      left[k] = 0; sc[k] = 0; fc[k] = 0;
    end else begin
      if (!pc && sc[k] < max_of(k)) sc[k] = sc[k] + 1;
      if (fi && fc[k] < max_of(k)) fc[k] = fc[k] + 1;
    end
  endtask

  task automatic step(input in_t i);
    exp_t [1:0] e;
    exp_t t;
    @(posedge clk);
    #1;
    rst = i.rst;
    hz_a.d_rs1 = i.rs1; hz_b.d_rs1 = i.rs1;
    hz_a.d_rs2 = i.rs2; hz_b.d_rs2 = i.rs2;
    hz_a.e_rd = i.rd; hz_b.e_rd = i.rd;
    hz_a.d_use_rs1 = i.u1; hz_b.d_use_rs1 = i.u1;
    hz_a.d_use_rs2 = i.u2; hz_b.d_use_rs2 = i.u2;
    hz_a.e_is_load = i.ld; hz_b.e_is_load = i.ld;
    hz_a.e_branch_taken = i.bt; hz_b.e_branch_taken = i.bt;
    hz_a.e_mdu_start = i.ms; hz_b.e_mdu_start = i.ms;
    hz_a.m_mem_wait = i.mw; hz_b.m_mem_wait = i.mw;
    for (int k = 0; k < 2; k++) begin
      model(k, i, t);
      e[k] = t;
    end
    q.push_back(e);
  endtask

  function automatic in_t idle();
    in_t i;
    i = '0;
    i.rst = 1'b1;
    return i;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  initial begin
    exp_t [1:0] p;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        p = q.pop_front();
        chk("a_ctl", 16'({hz_a.pc_enable, hz_a.fd_enable,
          hz_a.de_enable, hz_a.em_enable, hz_a.mw_enable,
          hz_a.fd_flush, hz_a.de_flush, hz_a.em_flush}),
          16'(p[0].ctl));
        chk("a_busy", 16'(hz_a.mdu_busy), 16'(p[0].busy));
        chk("a_stall", a_stall, p[0].sc);
        chk("a_flush", a_flush, p[0].fc);
        chk("b_ctl", 16'({hz_b.pc_enable, hz_b.fd_enable,
          hz_b.de_enable, hz_b.em_enable, hz_b.mw_enable,
          hz_b.fd_flush, hz_b.de_flush, hz_b.em_flush}),
          16'(p[1].ctl));
        chk("b_busy", 16'(hz_b.mdu_busy), 16'(p[1].busy));
        chk("b_stall", 16'(b_stall), p[1].sc);
        chk("b_flush", 16'(b_flush), p[1].fc);
      end
    end
  end

  initial begin
    in_t i;
    in_t r;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      left[k] = 0; sc[k] = 0; fc[k] = 0;
    end
    rst = 1'b0;
    hz_a.d_rs1 = '0; hz_a.d_rs2 = '0; hz_a.e_rd = '0;
    hz_a.d_use_rs1 = 0; hz_a.d_use_rs2 = 0; hz_a.e_is_load = 0;
    hz_a.e_branch_taken = 0; hz_a.e_mdu_start = 0;
    hz_a.m_mem_wait = 0;
    hz_b.d_rs1 = '0; hz_b.d_rs2 = '0; hz_b.e_rd = '0;
    hz_b.d_use_rs1 = 0; hz_b.d_use_rs2 = 0; hz_b.e_is_load = 0;
    hz_b.e_branch_taken = 0; hz_b.e_mdu_start = 0;
    hz_b.m_mem_wait = 0;
    repeat (3) @(posedge clk);

    step(idle());
    i = idle(); i.ld = 1; i.rd = 5; i.rs2 = 5; i.u2 = 1;
    step(i);
    step(idle());
    i.rd = 0; i.rs2 = 0;
    step(i);
    step(idle());

    step(r);
    i = idle(); i.ms = 1;
    step(i);
    repeat (5) step(idle());

    step(r);
    step(i);
    step(idle());
    i = idle(); i.mw = 1;
    step(i); step(i);
    repeat (4) step(idle());

    step(r);
    i = idle(); i.bt = 1; i.ld = 1; i.rd = 7; i.rs1 = 7; i.u1 = 1;
    step(i);
    step(idle());

    i = idle(); i.ms = 1;
    step(i);
    step(idle());
    step(r);
    repeat (2) step(idle());

    step(r);
    i = idle(); i.ld = 1; i.rd = 3; i.rs1 = 3; i.u1 = 1;
    repeat (20) step(i);
    step(idle());

    for (int n = 0; n < 400; n++) begin
      i = idle();
      i.rst = ($urandom_range(63) != 0);
      i.ms  = ($urandom_range(7) == 0);
      i.bt  = !i.ms && ($urandom_range(5) == 0);
      i.mw  = ($urandom_range(5) == 0);
      i.ld  = $urandom_range(1) != 0;
      i.u1  = $urandom_range(1) != 0;
      i.u2  = $urandom_range(1) != 0;
      i.rd  = 5'($urandom_range(7));
      i.rs1 = 5'($urandom_range(7));
      i.rs2 = 5'($urandom_range(7));
      step(i);
    end

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
